// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order response
// queue, and redirect flush with squashing of responses already in flight.
module inst_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int PC_INC = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  output logic                       o_imem_req,
  output logic [ADDR_W-1:0]          o_imem_addr,
  input  logic                       i_imem_ack,
  input  logic                       i_imem_rvalid,
  input  logic [INST_W-1:0]          i_imem_rdata,
  input  logic                       i_redirect,
  input  logic [ADDR_W-1:0]          i_redirect_pc,
  output logic                       o_inst_valid,
  output logic [INST_W-1:0]          o_inst,
  output logic [ADDR_W-1:0]          o_inst_pc,
  input  logic                       i_inst_ready,
  output logic [$clog2(DEPTH):0]     o_outstanding
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] fetch_pc, resp_pc;
  logic [CW-1:0]     count, outstanding, drop, outstanding_nxt;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [INST_W-1:0] q_inst [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [CW:0]       credit;
  logic              fire, rsp, push, pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // A request slot is only granted if its response is guaranteed a queue entry.
  always_comb begin
    state_nxt  = state;
    o_imem_req = 1'b0;
    credit     = {1'b0, count} + {1'b0, outstanding};
    if (state == IDLE && i_start && !i_redirect) state_nxt = RUN;
    if (state == RUN && !i_redirect && credit < (CW+1)'(DEPTH)) o_imem_req = 1'b1;
  end

  assign fire            = o_imem_req & i_imem_ack;
  assign rsp             = i_imem_rvalid & (outstanding != '0);
  assign push            = rsp & (drop == '0) & !i_redirect;
  assign pop             = o_inst_valid & i_inst_ready;
  assign outstanding_nxt = outstanding + CW'(fire) - CW'(rsp);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (i_redirect) begin
        // Everything still in flight belongs to the old path and must be squashed.
        fetch_pc <= i_redirect_pc;
        resp_pc  <= i_redirect_pc;
        drop     <= outstanding_nxt;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (fire) fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
        if (rsp && drop != '0) drop <= drop - CW'(1);
        if (push) begin
          resp_pc <= resp_pc + ADDR_W'(PC_INC);
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      q_inst[wr_ptr] <= i_imem_rdata;
      q_pc[wr_ptr]   <= resp_pc;
    end
  end

  assign o_imem_addr   = fetch_pc;
  assign o_inst_valid  = (count != '0);
  assign o_inst        = o_inst_valid ? q_inst[rd_ptr] : '0;
  assign o_inst_pc     = o_inst_valid ? q_pc[rd_ptr]   : '0;
  assign o_outstanding = outstanding;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(push && !pop && count == CW'(DEPTH)));
  a_credit: assert property (@(posedge i_clk) disable iff (i_rst)
    ({1'b0, count} + {1'b0, outstanding}) <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench: in-order 1-cycle memory model, fetch/pop logs, hand-computed expectations.
module tb_inst_fetch_queue;
  logic        clk = 0;
  logic        rst, start, ack, rvalid, redirect, ready, mem_en;
  logic [31:0] rdata, rpc;
  logic        req, ivld, req4, ivld4;
  logic [31:0] addr, inst, ipc, addr4, inst4, ipc4;
  logic [2:0]  outst, outst4;

  int n_chk = 0, n_fail = 0;
  logic [31:0] pend[$], addr_log[$], addr4_log[$], pc_log[$], inst_log[$], pc4_log[$];

  always #5 clk = ~clk;

  inst_fetch_queue u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_ack(ack), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(rpc), .o_inst_valid(ivld), .o_inst(inst),
    .o_inst_pc(ipc), .i_inst_ready(ready), .o_outstanding(outst));

  inst_fetch_queue #(.PC_INC(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_imem_req(req4), .o_imem_addr(addr4),
    .i_imem_ack(ack), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(rpc), .o_inst_valid(ivld4), .o_inst(inst4),
    .o_inst_pc(ipc4), .i_inst_ready(ready), .o_outstanding(outst4));

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: memory drives its response, sample after settle, then advance to next negedge.
  task automatic tick();
    rvalid = mem_en && pend.size() > 0;
    rdata  = rvalid ? inst_of(pend[0]) : '0;
    #1;
    if (req && ack)    addr_log.push_back(addr);
    if (req4 && ack)   addr4_log.push_back(addr4);
    if (ivld && ready) begin pc_log.push_back(ipc); inst_log.push_back(inst); end
    if (ivld4 && ready) pc4_log.push_back(ipc4);
    if (rst) pend.delete();
    else begin
      if (rvalid) void'(pend.pop_front());
      if (req && ack) pend.push_back(addr);
    end
    @(negedge clk);
  endtask

  task automatic clr_logs();
    addr_log.delete(); addr4_log.delete(); pc_log.delete(); inst_log.delete(); pc4_log.delete();
  endtask

  task automatic do_reset();
    rst = 1; start = 0; redirect = 0; rpc = '0; ack = 0; mem_en = 0; ready = 0;
    tick(); tick();
    rst = 0;
    clr_logs();
  endtask

  initial begin
    rvalid = 0; rdata = '0;
    // 1: streaming, one instruction per cycle
    do_reset();
    chk("rst_req", 32'(req), 0);
    chk("rst_vld", 32'(ivld), 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", ipc, 0);
    chk("rst_outst", 32'(outst), 0);
    chk("rst_inst4", inst4, 0);
    tick();
    chk("idle_req", 32'(req), 0);
    ack = 1; mem_en = 1; ready = 1; start = 1; tick(); start = 0;
    repeat (8) tick();
    chk("s1_nfetch", 32'(addr_log.size()), 8);
    chk("s1_npop", 32'(pc_log.size()), 6);
    for (int i = 0; i < 4; i++) begin
      chk("s1_addr", addr_log[i], 32'(i));
      chk("s1_pc", pc_log[i], 32'(i));
    end
    chk("s1_inst2", inst_log[2], 32'hC0DE_0002);

    // 2: decode stalled -> credit limit
    do_reset();
    ack = 1; mem_en = 1; start = 1; tick(); start = 0;
    repeat (8) tick();
    chk("s2_nfetch", 32'(addr_log.size()), 4);
    chk("s2_req", 32'(req), 0);
    chk("s2_outst", 32'(outst), 0);
    chk("s2_head", ipc, 0);
    ready = 1;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) chk("s2_pc", pc_log[i], 32'(i));
    chk("s2_resume", addr_log[4], 32'h4);

    // 3: address held under stall, then redirect with 3 outstanding + 1 queued
    do_reset();
    start = 1; tick(); start = 0; tick(); tick();
    chk("s3_stall_req", 32'(req), 1);
    chk("s3_stall_addr", addr, 0);
    chk("s3_stall_n", 32'(addr_log.size()), 0);
    ack = 1; repeat (4) tick();
    chk("s3_outst4", 32'(outst), 4);
    mem_en = 1; tick(); mem_en = 0;
    chk("s3_queued", 32'(ivld), 1);
    redirect = 1; rpc = 32'h40; tick(); redirect = 0;
    chk("s3_flush_vld", 32'(ivld), 0);
    chk("s3_outst3", 32'(outst), 3);
    mem_en = 1; ready = 1;
    repeat (10) tick();
    chk("s3_pc0", pc_log[0], 32'h40);
    chk("s3_inst0", inst_log[0], 32'hC0DE_0040);
    chk("s3_pc1", pc_log[1], 32'h41);

    // 4: redirect coinciding with rvalid and pop
    do_reset();
    ack = 1; start = 1; tick(); start = 0;
    repeat (4) tick();
    mem_en = 1; tick();
    ready = 1; redirect = 1; rpc = 32'h80; tick(); redirect = 0;
    chk("s4_outst", 32'(outst), 2);
    chk("s4_vld", 32'(ivld), 0);
    repeat (8) tick();
    chk("s4_pc0", pc_log[0], 0);
    chk("s4_inst0", inst_log[0], 32'hC0DE_0000);
    chk("s4_pc1", pc_log[1], 32'h80);
    chk("s4_inst1", inst_log[1], 32'hC0DE_0080);

    // 6: reset mid-flight (2 outstanding, 2 queued), then redirect while idle
    do_reset();
    ack = 1; start = 1; tick(); start = 0;
    repeat (4) tick();
    mem_en = 1; tick(); tick();
    chk("s6_pre_outst", 32'(outst), 2);
    chk("s6_pre_vld", 32'(ivld), 1);
    rst = 1; mem_en = 0; tick(); rst = 0;
    clr_logs();
    chk("s6_req", 32'(req), 0);
    chk("s6_vld", 32'(ivld), 0);
    chk("s6_inst", inst, 0);
    chk("s6_pc", ipc, 0);
    chk("s6_outst", 32'(outst), 0);
    repeat (3) tick();
    chk("s6_nfetch", 32'(addr_log.size()), 0);
    redirect = 1; rpc = 32'h20; tick(); redirect = 0;
    chk("s6_idle_req", 32'(req), 0);
    start = 1; tick(); start = 0; tick();
    chk("s6_addr", addr_log[0], 32'h20);

    // 5: byte-addressed wrap at the top of the address space
    do_reset();
    ack = 1; mem_en = 1; ready = 1; start = 1; tick(); start = 0;
    redirect = 1; rpc = 32'hFFFF_FFFC; tick(); redirect = 0;
    repeat (6) tick();
    chk("s5_addr0", addr4_log[0], 32'hFFFF_FFFC);
    chk("s5_addr1", addr4_log[1], 32'h0);
    chk("s5_addr2", addr4_log[2], 32'h4);
    chk("s5_pc0", pc4_log[0], 32'hFFFF_FFFC);
    chk("s5_pc1", pc4_log[1], 32'h0);
    chk("s5_req", 32'(req4), 1);
    chk("s5_w1_addr1", addr_log[1], 32'hFFFF_FFFD);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
